// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse and synchronous flush.
// Optional registered occupancy output on port occ when PIPE_REG_CHAIN_OCC_EN is defined.
`timescale 1ns/1ps
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_src_v;
  logic [DEPTH-1:0] w_v_nxt;
  logic [WIDTH-1:0] w_src_d [DEPTH];

  // A stage advances if the downstream accepts or any stage ahead of it is empty.
  always_comb begin : adv_chain
    logic w_acc;
    w_acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_adv[i] = w_acc;
      w_acc    = w_acc | ~r_v[i];
    end
  end

  assign w_load   = ~r_v | w_adv;
  assign in_ready = w_load[0] & ~flush;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
    if (gi == 0) begin : g_head
      assign w_src_v[gi] = in_valid;
      assign w_src_d[gi] = in_data;
    end else begin : g_body
      assign w_src_v[gi] = r_v[gi-1];
      assign w_src_d[gi] = r_d[gi-1];
    end
  end

  assign w_v_nxt = flush ? '0 : ((w_load & w_src_v) | (~w_load & r_v));

  // Data only moves with a valid source, so idle cycles never disturb held data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_v <= w_v_nxt;
      if (!flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_load[i] && w_src_v[i]) begin
            r_d[i] <= w_src_d[i];
          end
        end
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] w_occ_nxt;
  logic [OCC_W-1:0] r_occ;

  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  assign occ = r_occ;
`endif

endmodule
